inv2_lane_arbiter: RTL

- Shares one external 2-bit inverter lane (the INV_2bit_540_270 datapath cell) between two requesters.
- Arbitrates round-robin and latches the winner's operand onto the lane inputs.
- Waits a programmable settle time, captures the lane output and returns it to the owning requester with a one-cycle valid pulse.
- Sits between the ALU operand muxes and the custom-cell inverter lane.

---
 rtl/inv2_lane_pkg.sv | 14 +
 rtl/arb2_rr.sv | 23 ++
 rtl/inv2_lane_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/inv2_lane_pkg.sv
// Shared types and constants for the two-requester inverter-lane arbiter.
package inv2_lane_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb2_rr.sv
// Combinational two-input round-robin picker; PRI breaks ties when both request.
module arb2_rr
    import inv2_lane_pkg::*;
(
    input  logic REQ0,
    input  logic REQ1,
    input  logic PRI,
    output logic ANY,
    output logic WIN
);

    always_comb begin
        ANY = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            WIN = PRI;
        end else if (REQ1) begin
            WIN = REQ_ID1;
        end else begin
            WIN = REQ_ID0;
        end
    end

endmodule

// File: rtl/inv2_lane_arbiter.sv
// Shares one 2-bit inverter lane between two requesters: round-robin grant,
// hold operand for EVAL_CYCLES, capture the lane output and return it to the owner.
module inv2_lane_arbiter
    import inv2_lane_pkg::*;
#(
    parameter int unsigned EVAL_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [1:0] DIN0,
    input  logic [1:0] DIN1,
    output logic       GNT0,
    output logic       GNT1,
    output logic [1:0] DP_IN,
    input  logic [1:0] DP_OUT,
    output logic [1:0] RES,
    output logic       RES_VLD0,
    output logic       RES_VLD1,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EVAL_CYCLES - 1);

    state_t           state_q, state_d;
    logic             pri_q, pri_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic [1:0]       dp_in_q, dp_in_d;
    logic [1:0]       res_q, res_d;
    logic             vld0_q, vld0_d;
    logic             vld1_q, vld1_d;
    logic             busy_q, busy_d;

    logic             any_req;
    logic             win_id;

    arb2_rr u_arb (
        .REQ0 (REQ0),
        .REQ1 (REQ1),
        .PRI  (pri_q),
        .ANY  (any_req),
        .WIN  (win_id)
    );

    // Reset discards any in-flight op without a result pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            pri_q   <= REQ_ID0;
            owner_q <= REQ_ID0;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            dp_in_q <= 2'b00;
            res_q   <= 2'b00;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            dp_in_q <= dp_in_d;
            res_q   <= res_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EVAL;
            EVAL:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        vld0_d  = 1'b0;
        vld1_d  = 1'b0;
        dp_in_d = dp_in_q;
        res_d   = res_q;
        pri_d   = pri_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt0_d  = (win_id == REQ_ID0);
                    gnt1_d  = (win_id == REQ_ID1);
                    dp_in_d = (win_id == REQ_ID1) ? DIN1 : DIN0;
                    owner_d = win_id;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                end
            end
            EVAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d  = DP_OUT;
                    vld0_d = (owner_q == REQ_ID0);
                    vld1_d = (owner_q == REQ_ID1);
                    pri_d  = ~owner_q;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign GNT0     = gnt0_q;
    assign GNT1     = gnt1_q;
    assign DP_IN    = dp_in_q;
    assign RES      = res_q;
    assign RES_VLD0 = vld0_q;
    assign RES_VLD1 = vld1_q;
    assign BUSY     = busy_q;

endmodule
